video_timing_src: RTL

Source end of the pixel stream (rgb/hsync/vsync/vde with valid/ready). It generates VGA-style raster timing and a selectable test pattern, and drives the stream into downstream register stages and the display path. Downstream back-pressure stalls the raster; it never drops or duplicates a beat. It is used for bring-up and as the default frame source when no capture path is attached.

---
 rtl/video_timing_src.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/video_timing_src.sv
// Test-pattern video source: VGA-style raster timing on a valid/ready beat stream.
// Back-pressure freezes the raster. Dropping en_i finishes the current frame before going idle.
module video_timing_src #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter logic        HSYNC_ACT = 1'b0,
  parameter logic        VSYNC_ACT = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [1:0]       pattern_sel_i,
  output logic [WIDTH-1:0] rgb_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             vde_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned C        = WIDTH / 3;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t        state, state_nx;
  logic [HW-1:0] h, h_nx;
  logic [VW-1:0] v, v_nx;
  logic [1:0]    pat, pat_nx;
  logic          valid_nx;
  logic          load;

  function automatic logic [WIDTH-1:0] pixel(input logic [31:0] hh, input logic [31:0] vv,
                                             input logic [1:0] pp);
    logic [2:0] bar;
    bar   = 3'((hh * 8) / H_ACTIVE);
    pixel = '0;
    if (hh < H_ACTIVE && vv < V_ACTIVE) begin
      unique case (pp)
        2'd0:    pixel = {{C{~bar[2]}}, {C{~bar[1]}}, {C{~bar[0]}}};
        2'd1:    pixel = WIDTH'(hh);
        2'd2:    pixel = (hh[3] ^ vv[3]) ? '1 : '0;
        default: pixel = '1;
      endcase
    end
  endfunction

  // (h,v) always names the beat currently presented; the next beat is loaded on its transfer.
  always_comb begin
    state_nx = state;
    h_nx     = h;
    v_nx     = v;
    pat_nx   = pat;
    valid_nx = valid_o;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (en_i) begin
          state_nx = RUN;
          h_nx     = '0;
          v_nx     = '0;
          pat_nx   = pattern_sel_i;
          valid_nx = 1'b1;
          load     = 1'b1;
        end
      end
      default: begin
        state_nx = en_i ? RUN : FINISH;
        if (valid_o && ready_i) begin
          if (state == FINISH && !en_i && h == H_LAST && v == V_LAST) begin
            state_nx = IDLE;
            valid_nx = 1'b0;
            h_nx     = '0;
            v_nx     = '0;
          end else begin
            load = 1'b1;
            if (h == H_LAST) begin
              h_nx = '0;
              if (v == V_LAST) begin
                v_nx   = '0;
                pat_nx = pattern_sel_i;
              end else begin
                v_nx = v + 1'b1;
              end
            end else begin
              h_nx = h + 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      h       <= '0;
      v       <= '0;
      pat     <= '0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      rgb_o   <= '0;
      vde_o   <= 1'b0;
      hsync_o <= ~HSYNC_ACT;
      vsync_o <= ~VSYNC_ACT;
    end else begin
      state   <= state_nx;
      h       <= h_nx;
      v       <= v_nx;
      pat     <= pat_nx;
      valid_o <= valid_nx;
      busy_o  <= (state_nx != IDLE);
      if (load) begin
        rgb_o   <= pixel(32'(h_nx), 32'(v_nx), pat_nx);
        vde_o   <= (32'(h_nx) < H_ACTIVE) && (32'(v_nx) < V_ACTIVE);
        hsync_o <= (32'(h_nx) >= HS_START && 32'(h_nx) < HS_END) ? HSYNC_ACT : ~HSYNC_ACT;
        vsync_o <= (32'(v_nx) >= VS_START && 32'(v_nx) < VS_END) ? VSYNC_ACT : ~VSYNC_ACT;
      end else if (!valid_nx) begin
        rgb_o   <= '0;
        vde_o   <= 1'b0;
        hsync_o <= ~HSYNC_ACT;
        vsync_o <= ~VSYNC_ACT;
      end
    end
  end

endmodule
